// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction/resolve path.
package bp_pkg;
  localparam int XLEN   = 32;
  localparam int PC_INC = 4;

  // Prediction recorded at fetch for one in-flight branch.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } pred_entry_t;

  // Fall-through PC of a branch; wraps at 32 bits.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(PC_INC);
  endfunction
endpackage

// File: rtl/pred_fifo.sv
// In-order queue of fetch predictions awaiting resolution. Flush wins over push.
module pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  pred_entry_t din_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int           PW        = $clog2(DEPTH);
  localparam logic [PW:0]  DEPTH_OCC = (PW+1)'(DEPTH);

  pred_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   occ_q, occ_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  // A pop frees the head slot on the same edge, so a full queue can still
  // take a push when the head is being retired in that cycle.
  assign pop_ok  = pop_i & ~empty_q;
  assign push_ok = push_i & (~full_q | pop_ok);

  // Next occupancy; flush empties the queue regardless of push/pop.
  always_comb begin
    occ_d = occ_q;
    if (flush_i)               occ_d = '0;
    else if (push_ok && !pop_ok) occ_d = occ_q + 1'b1;
    else if (pop_ok && !push_ok) occ_d = occ_q - 1'b1;
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      occ_q   <= occ_d;
      full_q  <= (occ_d == DEPTH_OCC);
      empty_q <= (occ_d == '0);
    end
  end

  // Entry storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Compares fetch predictions against execute outcomes, raises a registered
// redirect, drives the target-buffer update port and keeps statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [XLEN-1:0]  push_pc,
  input  logic             push_pred_taken,
  input  logic [XLEN-1:0]  push_pred_target,
  output logic             full,
  output logic             empty,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [XLEN-1:0]  resolve_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  pred_entry_t      push_ent, head;
  logic             res_acc, mis_cond, flush;
  logic             mispredict_q, upd_valid_q, upd_taken_q;
  logic [XLEN-1:0]  redirect_pc_q, upd_pc_q, upd_target_q;
  logic [CNT_W-1:0] branch_cnt_q, mis_cnt_q;

  assign push_ent = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};
  assign res_acc  = resolve_valid & ~empty;
  assign flush    = res_acc & mis_cond;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_valid),
    .pop_i   (resolve_valid),
    .flush_i (flush),
    .din_i   (push_ent),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Wrong direction, or right "taken" direction with the wrong target.
  always_comb begin
    mis_cond = (head.pred_taken != resolve_taken) ||
               (head.pred_taken && resolve_taken && (head.pred_target != resolve_target));
  end

  // One-cycle redirect and update pulses, plus the data they carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
      upd_taken_q   <= 1'b0;
    end else begin
      mispredict_q <= res_acc & mis_cond;
      upd_valid_q  <= res_acc;
      if (res_acc) begin
        redirect_pc_q <= resolve_taken ? resolve_target : next_seq_pc(head.pc);
        upd_pc_q      <= head.pc;
        upd_taken_q   <= resolve_taken;
        upd_target_q  <= resolve_taken ? resolve_target : head.pred_target;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      if (res_acc && !(&branch_cnt_q))         branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (res_acc && mis_cond && !(&mis_cnt_q)) mis_cnt_q   <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign upd_valid        = upd_valid_q;
  assign upd_pc           = upd_pc_q;
  assign upd_target       = upd_target_q;
  assign upd_taken        = upd_taken_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mis_cnt_q;
endmodule
